// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter: grants I-cache or D-cache one transaction at a time,
// latches the winner's AR payload and steers the R beats back until rlast.
module axi_read_arbiter #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter bit         RR_MODE    = 1'b0,
  parameter logic [3:0] I_ID       = 4'd0,
  parameter logic [3:0] D_ID       = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic                  i_arvalid,
  output logic                  i_arready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rlast,
  output logic                  i_rvalid,
  input  logic                  i_rready,
  input  logic [ADDR_WIDTH-1:0] d_araddr,
  input  logic [7:0]            d_arlen,
  input  logic [2:0]            d_arsize,
  input  logic                  d_arvalid,
  output logic                  d_arready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rlast,
  output logic                  d_rvalid,
  input  logic                  d_rready,
  output logic [3:0]            m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [3:0]            m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  busy,
  output logic                  rid_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [3:0]            id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } ar_t;

  state_t state, state_nxt;
  ar_t    ar_q, ar_nxt;
  logic   own_d;      // 1: D-cache owns the channel
  logic   rr_last_d;  // 1: D-cache was served last
  logic   gnt_d;
  logic   req_any;
  logic   own_rready;
  logic   last_hs;

  assign req_any = i_arvalid | d_arvalid;

  // Contention: fixed priority favours D, round-robin favours whoever was not served last.
  always_comb begin
    if (i_arvalid && d_arvalid) gnt_d = RR_MODE ? ~rr_last_d : 1'b1;
    else                        gnt_d = d_arvalid;
    ar_nxt = gnt_d ? {D_ID, d_araddr, d_arlen, d_arsize}
                   : {I_ID, i_araddr, i_arlen, i_arsize};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    i_arready  = 1'b0;
    d_arready  = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    i_rlast    = 1'b0;
    d_rlast    = 1'b0;
    last_hs    = 1'b0;
    own_rready = own_d ? d_rready : i_rready;
    case (state)
      IDLE: if (req_any) state_nxt = ADDR;
      ADDR: begin
        m_arvalid = 1'b1;
        i_arready = ~own_d & m_arready;
        d_arready =  own_d & m_arready;
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        m_rready = own_rready;
        i_rvalid = ~own_d & m_rvalid;
        d_rvalid =  own_d & m_rvalid;
        i_rlast  = ~own_d & m_rlast;
        d_rlast  =  own_d & m_rlast;
        last_hs  = m_rvalid & own_rready & m_rlast;
        if (last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_d     <= 1'b1;
      rr_last_d <= 1'b1;
      rid_err   <= 1'b0;
      ar_q      <= '0;
    end else begin
      // Payload is captured only on the grant, so later arvalid traffic cannot disturb it.
      if (state == IDLE && req_any) begin
        own_d <= gnt_d;
        ar_q  <= ar_nxt;
      end
      if (state == DATA && m_rvalid && m_rid != ar_q.id) rid_err <= 1'b1;
      if (last_hs) rr_last_d <= own_d;
    end
  end

  assign m_arid    = ar_q.id;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = 2'b01;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign busy      = (state != IDLE);

endmodule
